clear_star_box: RTL and testbench

CLEAR_STAR_BOX -- requirements
Module: clear_star_box

---
 rtl/clear_star_box.sv | 115 +++++++++++
 tb/tb_clear_star_box.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clear_star_box.sv
// Erases a rectangular box of pixels by streaming FILL writes, row-major,
// into a pixel memory; rejects boxes that are inverted or outside the image.
module clear_star_box #(
  parameter int unsigned XSZ    = 3,
  parameter int unsigned YSZ    = 3,
  parameter int unsigned ADDRSZ = 6,
  parameter int unsigned COLSZ  = 3,
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned HEIGHT = 6,
  parameter int unsigned FILL   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [XSZ-1:0]    xLeft,
  input  logic [XSZ-1:0]    xRight,
  input  logic [YSZ-1:0]    yTop,
  input  logic [YSZ-1:0]    yBottom,
  output logic [ADDRSZ-1:0] wrAddr,
  output logic [COLSZ-1:0]  wrData,
  output logic              wrEn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDRSZ:0]   pixCount
);

  localparam int unsigned PW = ADDRSZ + 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  state_t            state, stateNext;
  logic [XSZ-1:0]    xL, xR, xCount, xCountNext;
  logic [YSZ-1:0]    yT, yB, yCount, yCountNext;
  logic [PW-1:0]     pixNext;
  logic [ADDRSZ-1:0] addrNext;
  logic              boundsBad;

  assign boundsBad = (xL > xR) || (yT > yB) ||
                     (32'(xR) >= WIDTH) || (32'(yB) >= HEIGHT);

  // Next-state, scan counters and the values the output registers will take
  always_comb begin
    stateNext  = state;
    xCountNext = xCount;
    yCountNext = yCount;
    pixNext    = pixCount;
    unique case (state)
      IDLE: if (start) stateNext = LOAD;
      LOAD: begin
        pixNext = '0;
        if (boundsBad) begin
          stateNext = ERR;
        end else begin
          xCountNext = xL;
          yCountNext = yT;
          stateNext  = WRITE;
        end
      end
      WRITE: begin
        pixNext = pixCount + PW'(1);
        if (xCount == xR && yCount == yB) begin
          stateNext = DONE;
        end else if (xCount < xR) begin
          xCountNext = xCount + XSZ'(1);
        end else begin
          xCountNext = xL;
          yCountNext = yCount + YSZ'(1);
        end
      end
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    addrNext = ADDRSZ'(32'(yCountNext) * WIDTH + 32'(xCountNext));
  end

  // Outputs are registered from the upcoming state so they line up with it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      xCount   <= '0;
      yCount   <= '0;
      pixCount <= '0;
      xL       <= '0;
      xR       <= '0;
      yT       <= '0;
      yB       <= '0;
      wrEn     <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= stateNext;
      xCount   <= xCountNext;
      yCount   <= yCountNext;
      pixCount <= pixNext;
      if (state == IDLE && start) begin
        xL <= xLeft;
        xR <= xRight;
        yT <= yTop;
        yB <= yBottom;
      end
      wrEn   <= (stateNext == WRITE);
      wrAddr <= addrNext;
      wrData <= COLSZ'(FILL);
      busy   <= (stateNext == LOAD) || (stateNext == WRITE);
      done   <= (stateNext == DONE);
      err    <= (stateNext == ERR);
    end
  end

endmodule

// File: tb/tb_clear_star_box.sv
// Scoreboard bench: stimulus queues expected writes/done/err with their cycle,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_clear_star_box;

  localparam int W = 6;
  localparam int KWR = 0, KDONE = 1, KERR = 2;

  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [2:0] xLeft = '0, xRight = '0, yTop = '0, yBottom = '0;
  logic [5:0] wrAddr;
  logic [2:0] wrData;
  logic       wrEn, busy, done, err;
  logic [6:0] pixCount;

  clear_star_box dut (
    .clk(clk), .resetn(resetn), .start(start),
    .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
    .wrAddr(wrAddr), .wrData(wrData), .wrEn(wrEn),
    .busy(busy), .done(done), .err(err), .pixCount(pixCount)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int cyc; int val;} exp_t;
  exp_t expQ[$];
  int cyc = 0, passed = 0, total = 0, busyCycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
  endtask

  // Monitor: every write/done/err must match the head of the scoreboard
  always @(negedge clk) begin
    int gk;
    exp_t e;
    if (busy) busyCycles++;
    if (wrEn || done || err) begin
      gk = wrEn ? KWR : (done ? KDONE : KERR);
      if (expQ.size() == 0) begin
        check("unexpected_output_kind", gk, -1);
      end else begin
        e = expQ.pop_front();
        check("kind", gk, e.kind);
        check("cycle", cyc, e.cyc);
        if (e.kind == KWR) begin
          check("wrAddr", int'(wrAddr), e.val);
          check("wrData", int'(wrData), 0);
        end else begin
          check("pixCount", int'(pixCount), e.val);
        end
      end
    end
  end

  // Issue start for one cycle; base is the cyc value seen during the LOAD cycle
  task automatic issue(input int xl, input int xr, input int yt, input int yb,
                       output int base);
    @(negedge clk);
    xLeft = 3'(xl); xRight = 3'(xr); yTop = 3'(yt); yBottom = 3'(yb);
    start = 1'b1;
    busyCycles = 0;
    base = cyc + 1;
  endtask

  // Model: writes in cycles base+1..base+N, done at base+N+1, err at base+1
  task automatic pushOp(input int xl, input int xr, input int yt, input int yb);
    int base, n;
    issue(xl, xr, yt, yb, base);
    if (xl > xr || yt > yb || xr >= W || yb >= 6) begin
      expQ.push_back('{KERR, base + 1, 0});
    end else begin
      n = 0;
      for (int y = yt; y <= yb; y++)
        for (int x = xl; x <= xr; x++) begin
          expQ.push_back('{KWR, base + 1 + n, y * W + x});
          n++;
        end
      expQ.push_back('{KDONE, base + 1 + n, n});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (expQ.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending_items", expQ.size(), 0);
    expQ.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int addrs[6];

    // Reset with start held high: reset wins, everything stays quiet
    resetn = 1'b0; start = 1'b1; xLeft = 3'd0; xRight = 3'd1; yTop = 3'd0; yBottom = 3'd1;
    repeat (3) @(negedge clk);
    check("rst_wrEn", int'(wrEn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_pixCount", int'(pixCount), 0);
    start = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Box x1..3 y2..3: hand-computed addresses
    addrs = '{13, 14, 15, 19, 20, 21};
    issue(1, 3, 2, 3, base);
    for (int i = 0; i < 6; i++) expQ.push_back('{KWR, base + 1 + i, addrs[i]});
    expQ.push_back('{KDONE, base + 7, 6});
    @(negedge clk);
    start = 1'b0;
    drain();
    check("box_busy_cycles", busyCycles, 7);
    check("box_pix_hold", int'(pixCount), 6);

    // Single pixel at bottom-right corner
    pushOp(5, 5, 5, 5);
    drain();
    check("single_busy_cycles", busyCycles, 2);

    // Full image
    pushOp(0, 5, 0, 5);
    drain();
    check("full_busy_cycles", busyCycles, 37);
    check("full_pix_hold", int'(pixCount), 36);

    // Rejected requests: inverted x, y out of range
    pushOp(4, 2, 0, 1);
    drain();
    check("errx_busy_cycles", busyCycles, 1);
    pushOp(0, 1, 0, 6);
    drain();
    check("erry_pix_hold", int'(pixCount), 0);

    // start re-pulsed mid-WRITE with other bounds must be ignored
    pushOp(0, 2, 1, 2);
    repeat (2) @(negedge clk);
    xLeft = 3'd4; xRight = 3'd5; yTop = 3'd0; yBottom = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("restart_pix", int'(pixCount), 6);

    // Reset after the third write of a 3x3 box
    issue(0, 2, 0, 2, base);
    for (int i = 0; i < 3; i++) expQ.push_back('{KWR, base + 1 + i, i});
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_wrEn", int'(wrEn), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_pix", int'(pixCount), 0);
    resetn = 1'b1;
    drain();
    pushOp(2, 3, 3, 4);
    drain();
    check("post_rst_pix", int'(pixCount), 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
